instruction_fetch: RTL and testbench

Front end of the MIPS pipeline, directly upstream of `Instruction_Decoder`. Owns the program counter and issues word fetches to instruction memory through a valid/ready request and response handshake. Holds the IF/ID pipeline register whose `Instruction_out` feeds the decoder's `Instruction_in`. Honours stalls from the hazard unit and PC redirects from branch and jump resolution.

---
 rtl/mips_pkg.sv | 20 ++
 rtl/instruction_fetch_if.sv | 27 ++
 rtl/if_id_register.sv | 46 ++++
 rtl/instruction_fetch.sv | 131 +++++++++++++
 tb/tb_instruction_fetch.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS front-end definitions: fetch FSM states, reset PC default,
// the NOP encoding used for flushes, and word-alignment helpers.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] WORD_ALIGN_MASK  = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2
  } fetch_state_e;

  // Clear the byte-offset bits so the address always points at a word.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return addr & WORD_ALIGN_MASK;
  endfunction

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory request/response bus: one valid/ready request channel
// and a response strobe with its data word.
interface instruction_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ready,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ready,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/if_id_register.sv
// IF/ID pipeline register. Flush wins over hold, hold wins over load, and a
// cycle with none of them inserts a bubble (valid drops, payload is kept).
module if_id_register
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_flush,
  input  logic        i_hold,
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc_plus4,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc_plus4,
  output logic        o_valid
);

  logic [31:0] r_instr_p1;
  logic [31:0] r_pc_plus4_p1;
  logic        r_vld_p1;

  // IF -> ID stage boundary: update the decoder-facing register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_instr_p1    <= NOP_INSTR;
      r_pc_plus4_p1 <= 32'h0000_0000;
      r_vld_p1      <= 1'b0;
    end else if (i_flush) begin
      r_instr_p1 <= NOP_INSTR;
      r_vld_p1   <= 1'b0;
    end else if (i_hold) begin
      r_vld_p1 <= r_vld_p1;
    end else if (i_load) begin
      r_instr_p1    <= i_instr;
      r_pc_plus4_p1 <= i_pc_plus4;
      r_vld_p1      <= 1'b1;
    end else begin
      r_vld_p1 <= 1'b0;
    end
  end

  assign o_instr    = r_instr_p1;
  assign o_pc_plus4 = r_pc_plus4_p1;
  assign o_valid    = r_vld_p1;

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch front end: owns the PC, issues one outstanding word fetch
// at a time, parks a stalled response in a hold buffer, and handles
// branch/jump redirects by flushing IF/ID and killing an in-flight response.
module instruction_fetch
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       stall_in,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  instruction_fetch_if.master        imem,
  output logic [31:0]                Instruction_out,
  output logic [31:0]                pc_plus4_out,
  output logic                       if_valid
);

  // PC advance wraps modulo 2^32.
  function automatic logic [31:0] pc_incr(input logic [31:0] pc);
    return pc + 32'd4;
  endfunction

  fetch_state_e r_state, w_state_nxt;
  logic [31:0]  r_pc, w_pc_nxt;
  logic         r_kill, w_kill_nxt;
  logic [31:0]  r_hold_word;
  logic         w_capture;
  logic         w_load;
  logic         w_flush;
  logic [31:0]  w_load_word;
  logic [31:0]  w_pc_plus4;
  logic         w_req;

  // A redirect must not launch a request to the stale PC, since the FSM
  // returns to FETCH and would lose track of it.
  assign w_req          = (r_state == FETCH) && !stall_in && !redirect_valid && !rst;
  assign w_pc_plus4     = pc_incr(r_pc);
  assign imem.imem_req  = w_req;
  assign imem.imem_addr = r_pc;

  // Next-state, PC and IF/ID control decode.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_capture   = 1'b0;
    w_load      = 1'b0;
    w_flush     = 1'b0;
    w_load_word = r_hold_word;
    if (redirect_valid) begin
      w_pc_nxt = word_align(redirect_pc);
      w_flush  = 1'b1;
      if ((r_state == WAIT) && !imem.imem_rvalid) begin
        // Response still in flight: remember to drop it when it lands.
        w_state_nxt = WAIT;
        w_kill_nxt  = 1'b1;
      end else begin
        w_state_nxt = FETCH;
        w_kill_nxt  = 1'b0;
      end
    end else begin
      case (r_state)
        FETCH: begin
          if (w_req && imem.imem_ready) begin
            w_state_nxt = WAIT;
          end
        end
        WAIT: begin
          if (imem.imem_rvalid) begin
            if (r_kill) begin
              w_kill_nxt  = 1'b0;
              w_state_nxt = FETCH;
            end else if (!stall_in) begin
              w_load      = 1'b1;
              w_load_word = imem.imem_rdata;
              w_pc_nxt    = w_pc_plus4;
              w_state_nxt = FETCH;
            end else begin
              w_capture   = 1'b1;
              w_state_nxt = HOLD;
            end
          end
        end
        HOLD: begin
          if (!stall_in) begin
            w_load      = 1'b1;
            w_pc_nxt    = w_pc_plus4;
            w_state_nxt = FETCH;
          end
        end
        default: w_state_nxt = FETCH;
      endcase
    end
  end

  // Control state: FSM, PC and kill flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= FETCH;
      r_pc    <= word_align(RESET_PC);
      r_kill  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
    end
  end

  // Hold buffer: parks a word that arrived while the decoder was stalled.
  always_ff @(posedge clk) begin
    if (w_capture) begin
      r_hold_word <= imem.imem_rdata;
    end
  end

  if_id_register u_if_id (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_load),
    .i_flush    (w_flush),
    .i_hold     (stall_in),
    .i_instr    (w_load_word),
    .i_pc_plus4 (w_pc_plus4),
    .o_instr    (Instruction_out),
    .o_pc_plus4 (pc_plus4_out),
    .o_valid    (if_valid)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: a memory responder with programmable latency,
// a transaction-level reference model compared every cycle, directed
// scenarios with literal expectations, and a second instance reset to the
// top word of the address space.
module tb_instruction_fetch;
  import mips_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Main DUT signals
  logic        rst, stall_in, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] Instruction_out, pc_plus4_out;
  logic        if_valid;
  instruction_fetch_if bus();

  // Wrap-around DUT signals
  logic        w_rst, w_stall, w_redir;
  logic [31:0] w_rpc;
  logic [31:0] w_instr, w_pc4;
  logic        w_valid;
  instruction_fetch_if wbus();

  instruction_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stall_in(stall_in), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .imem(bus),
    .Instruction_out(Instruction_out), .pc_plus4_out(pc_plus4_out), .if_valid(if_valid)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(w_rst), .stall_in(w_stall), .redirect_valid(w_redir),
    .redirect_pc(w_rpc), .imem(wbus),
    .Instruction_out(w_instr), .pc_plus4_out(w_pc4), .if_valid(w_valid)
  );

  int checks = 0;
  int errors = 0;

  // Stimulus requests, applied at the next falling edge
  logic        n_rst, n_stall, n_redir, n_ready;
  logic [31:0] n_rpc;
  logic        stray;
  logic [31:0] stray_data;
  logic        nw_rst, nw_rvalid;
  logic [31:0] nw_rdata;
  // Memory responder
  logic        mem_auto;
  int          mem_lat;
  logic        mem_pend;
  int          mem_cnt;
  logic [31:0] mem_paddr;
  logic        started = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    if (a == 32'h4) return 32'h0000_0000;
    return 32'h8C00_0000 | a;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs on the falling edge, then let the memory
  // observe whether a request was accepted at the coming rising edge.
  task automatic tick();
    @(negedge clk);
    rst            = n_rst;
    stall_in       = n_stall;
    redirect_valid = n_redir;
    redirect_pc    = n_rpc;
    bus.imem_ready = n_ready;
    bus.imem_rvalid = 1'b0;
    if (mem_pend) begin
      mem_cnt--;
      if (mem_cnt == 0) begin
        bus.imem_rvalid = 1'b1;
        bus.imem_rdata  = mem_word(mem_paddr);
        mem_pend        = 1'b0;
      end
    end
    if (stray) begin
      bus.imem_rvalid = 1'b1;
      bus.imem_rdata  = stray_data;
    end
    w_rst            = nw_rst;
    wbus.imem_ready  = 1'b1;
    wbus.imem_rvalid = nw_rvalid;
    wbus.imem_rdata  = nw_rdata;
    started = 1'b1;
    #4;
    if (mem_auto && bus.imem_req && bus.imem_ready) begin
      mem_pend  = 1'b1;
      mem_cnt   = mem_lat;
      mem_paddr = bus.imem_addr;
    end
  endtask

  // Reference model: tracks the PC, whether a fetch is outstanding, whether
  // its response is to be discarded, and a parked word; then reproduces the
  // decoder-facing register from those.
  logic [31:0] m_pc = 32'h0, m_hword = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0;
  logic        m_busy = 1'b0, m_kill = 1'b0, m_held = 1'b0, m_valid = 1'b0, m_init = 1'b0;

  initial begin
    logic        e_req, got;
    logic [31:0] word;
    forever begin
      @(negedge clk);
      #3;
      if (started) begin
        e_req = !rst && !redirect_valid && !stall_in && !m_busy && !m_held;
        chk("model_imem_req", {31'b0, bus.imem_req}, {31'b0, e_req});
        if (e_req) chk("model_imem_addr", bus.imem_addr, m_pc);
        if (m_init) begin
          chk("model_instr", Instruction_out, m_instr);
          chk("model_pc_plus4", pc_plus4_out, m_pc4);
          chk("model_if_valid", {31'b0, if_valid}, {31'b0, m_valid});
        end
        if (rst) begin
          m_pc = 32'h0; m_busy = 0; m_kill = 0; m_held = 0;
          m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 0; m_init = 1;
        end else if (redirect_valid) begin
          m_pc = {redirect_pc[31:2], 2'b00};
          m_instr = 32'h0; m_valid = 0; m_held = 0;
          if (m_busy && !bus.imem_rvalid) m_kill = 1;
          else begin m_busy = 0; m_kill = 0; end
        end else begin
          got = 0; word = 32'h0;
          if (m_busy && bus.imem_rvalid) begin
            m_busy = 0;
            if (m_kill) m_kill = 0;
            else if (stall_in) begin m_held = 1; m_hword = bus.imem_rdata; end
            else begin got = 1; word = bus.imem_rdata; end
          end else if (m_held && !stall_in) begin
            got = 1; word = m_hword; m_held = 0;
          end
          if (e_req && bus.imem_ready) m_busy = 1;
          if (got) begin
            m_instr = word; m_pc4 = m_pc + 32'd4; m_valid = 1; m_pc = m_pc + 32'd4;
          end else if (!stall_in) m_valid = 0;
        end
      end
    end
  end

  initial begin
    int waited;
    n_rst = 1; n_stall = 0; n_redir = 0; n_rpc = 32'h0; n_ready = 1;
    stray = 0; stray_data = 32'h0; nw_rst = 1; nw_rvalid = 0; nw_rdata = 32'h0;
    mem_auto = 1; mem_lat = 1; mem_pend = 0; mem_cnt = 0; mem_paddr = 32'h0;
    w_stall = 0; w_redir = 0; w_rpc = 32'h0;

    // Reset, zero-wait memory
    tick(); tick();
    chk("rst_req", {31'b0, bus.imem_req}, 32'h0);
    chk("rst_instr", Instruction_out, NOP_INSTR);
    chk("rst_pc4", pc_plus4_out, 32'h0);
    chk("rst_valid", {31'b0, if_valid}, 32'h0);
    n_rst = 0; tick();
    chk("first_req", {31'b0, bus.imem_req}, 32'h1);
    chk("first_addr", bus.imem_addr, 32'h0);
    tick();
    chk("wait_req", {31'b0, bus.imem_req}, 32'h0);
    tick();
    chk("i0_instr", Instruction_out, 32'h2008_0005);
    chk("i0_pc4", pc_plus4_out, 32'h4);
    chk("i0_valid", {31'b0, if_valid}, 32'h1);
    chk("i1_addr", bus.imem_addr, 32'h4);
    tick(); tick();
    chk("i1_pc4", pc_plus4_out, 32'h8);
    chk("i1_instr", Instruction_out, 32'h0);
    chk("i2_addr", bus.imem_addr, 32'h8);

    // Stall during WAIT for three cycles
    n_stall = 1; tick();
    chk("stall_req0", {31'b0, bus.imem_req}, 32'h0);
    tick();
    chk("stall_frozen_pc4", pc_plus4_out, 32'h8);
    chk("stall_req1", {31'b0, bus.imem_req}, 32'h0);
    tick();
    n_stall = 0; tick(); tick();
    chk("held_instr", Instruction_out, 32'h8C00_0008);
    chk("held_pc4", pc_plus4_out, 32'hC);
    chk("held_valid", {31'b0, if_valid}, 32'h1);
    chk("after_hold_addr", bus.imem_addr, 32'hC);

    // Redirect while the fetch of 0x10 is outstanding
    tick();
    mem_lat = 2; tick();
    chk("req_0x10", bus.imem_addr, 32'h10);
    n_redir = 1; n_rpc = 32'h0000_0043; tick();
    n_redir = 0; tick();
    chk("killed_valid", {31'b0, if_valid}, 32'h0);
    chk("killed_instr", Instruction_out, NOP_INSTR);
    mem_lat = 1; tick();
    chk("redir_req", {31'b0, bus.imem_req}, 32'h1);
    chk("redir_addr", bus.imem_addr, 32'h40);

    // Redirect together with a stall
    tick();
    n_stall = 1; n_redir = 1; n_rpc = 32'h0000_0100; tick();
    chk("pre_flush_instr", Instruction_out, 32'h8C00_0040);
    chk("pre_flush_valid", {31'b0, if_valid}, 32'h1);
    n_stall = 0; n_redir = 0; tick();
    chk("flush_instr", Instruction_out, NOP_INSTR);
    chk("flush_valid", {31'b0, if_valid}, 32'h0);
    chk("flush_addr", bus.imem_addr, 32'h100);

    // Mixed stalls, back-pressure, latency and redirects (incl. PC wrap)
    for (int i = 0; i < 40; i++) begin
      n_stall = (i % 7 == 3) || (i % 7 == 4);
      n_ready = (i % 5 != 2);
      mem_lat = (i < 20) ? 1 : 2;
      n_redir = (i == 14) || (i == 27) || (i == 33);
      n_rpc   = (i == 14) ? 32'h0000_0202 : (i == 27) ? 32'hFFFF_FFFE : 32'h0000_0500;
      tick();
    end

    // Drain, then reset with a request outstanding and a stray response
    n_stall = 0; n_redir = 0; n_ready = 0; mem_lat = 1;
    waited = 0;
    while (!bus.imem_req && waited < 8) begin tick(); waited++; end
    chk("drain_req", {31'b0, bus.imem_req}, 32'h1);
    mem_auto = 0; n_ready = 1; tick();
    tick();
    chk("orphan_wait_req", {31'b0, bus.imem_req}, 32'h0);
    n_rst = 1; tick();
    n_rst = 0; n_ready = 0; stray = 1; stray_data = 32'hDEAD_BEEF; tick();
    chk("stray_req", {31'b0, bus.imem_req}, 32'h1);
    chk("stray_addr", bus.imem_addr, 32'h0);
    stray = 0; tick();
    chk("stray_instr", Instruction_out, NOP_INSTR);
    chk("stray_pc4", pc_plus4_out, 32'h0);
    chk("stray_valid", {31'b0, if_valid}, 32'h0);
    n_ready = 1; mem_auto = 1; tick(); tick(); tick();
    chk("restart_instr", Instruction_out, 32'h2008_0005);
    chk("restart_pc4", pc_plus4_out, 32'h4);

    // Wrap-around from RESET_PC = 0xFFFF_FFFC
    nw_rst = 0; tick();
    chk("wrap_req", {31'b0, wbus.imem_req}, 32'h1);
    chk("wrap_addr0", wbus.imem_addr, 32'hFFFF_FFFC);
    nw_rvalid = 1; nw_rdata = 32'h2402_0001; tick();
    chk("wrap_wait_req", {31'b0, wbus.imem_req}, 32'h0);
    nw_rvalid = 0; tick();
    chk("wrap_instr", w_instr, 32'h2402_0001);
    chk("wrap_pc4", w_pc4, 32'h0);
    chk("wrap_valid", {31'b0, w_valid}, 32'h1);
    chk("wrap_addr1", wbus.imem_addr, 32'h0);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
